count_descendente_100: RTL and testbench
========================================

Name: count_descendente_100

Overview:
- Synchronous modulo-100 down counter, the descending counterpart of the team's ascending mod-100 counter.
- Counts MAX_COUNT, MAX_COUNT-1, ... 0, then wraps to MAX_COUNT.
- Adds enable, synchronous parallel load, a registered BCD view, and a wrap (borrow) pulse so it can act as a countdown timer in later lab blocks.

Parameters:
- WIDTH, 7, bit width of the binary count.
- MAX_COUNT, 99, terminal (top) value. Counter range is 0..MAX_COUNT. Must be ≤ 99 and < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- async_reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  count-down enable, sampled on the rising edge of clk.
- load  input  1  synchronous load request; has priority over enable.
- load_value  input  WIDTH  value to load.
- count_out  output  WIDTH  registered binary count.
- tens_bcd  output  4  registered BCD tens digit of count_out.
- units_bcd  output  4  registered BCD units digit of count_out.
- zero_flag  output  1  combinational, high when count_out == 0.
- borrow_pulse  output  1  registered, high for exactly one cycle after a wrap from 0 to MAX_COUNT.

Behaviour:
- Reset (async_reset_n low, asynchronous assert, synchronous-edge release):
  - count_out = MAX_COUNT; tens_bcd/units_bcd = BCD of MAX_COUNT (9/9 by default); borrow_pulse = 0.
  - zero_flag therefore reads 0.
- First edge after reset release already acts on load/enable; there is no dead cycle.
- Per rising edge, in priority order:
  1. load = 1: count_out <= min(load_value, MAX_COUNT); BCD outputs <= BCD of the loaded value; borrow_pulse <= 0.
  2. enable = 1 and count_out > 0: count_out <= count_out - 1; BCD decrements in step; borrow_pulse <= 0.
  3. enable = 1 and count_out == 0: count_out <= MAX_COUNT; BCD <= BCD of MAX_COUNT; borrow_pulse <= 1.
  4. Otherwise: hold all values; borrow_pulse <= 0.
- Latency: one clock from the enable/load edge to the new count_out.
- BCD decrement rule:
  - units 0 -> 9 with a borrow into tens; tens decrements on that borrow.
  - At 00 the wrap rule (3) applies, not the digit rule.
- Invariant, every cycle after reset: tens_bcd*10 + units_bcd == count_out. This holds even when MAX_COUNT < 99.
- Load saturation: load_value > MAX_COUNT (e.g. 120) loads MAX_COUNT. No error flag.
- load and enable asserted together: load wins and no decrement occurs that cycle.
- Load of 0 with enable held: next edge wraps to MAX_COUNT with borrow_pulse = 1.
- Reset mid-count: all outputs return to reset values immediately, independent of clk.
- No X propagation: every register has a reset value. Unused BCD codes (10–15) are never produced.

Decomposition:
- Shared package/include (count_pkg): constants DEFAULT_WIDTH = 7, DEFAULT_MAX_COUNT = 99, BCD_W = 4; function to_bcd2(value) returning {tens, units}. The ascending counter and this block share it.
- Sub-module bcd_digit_down: one 4-bit BCD digit with inputs clk, async_reset_n, dec, load, load_digit, reset_digit, and outputs digit, borrow_out (digit == 0 && dec).
  - Instantiate twice: the units digit is fed by the top-level decrement; the tens digit is fed by the units borrow_out.
  - The wrap and load cases override both digits.
- Top level holds the binary register, the saturation compare, and the borrow_pulse register.

Test Plan:
- Reset: hold async_reset_n = 0 for 20 ns, then release -> count_out = 99, tens/units = 9/9, zero_flag = 0, borrow_pulse = 0. Re-assert at a mid-cycle time -> outputs change with no clk edge.
- Full countdown: enable = 1 for 105 cycles -> sequence 99, 98, ... 1, 0, 99, 98, 97, 96, 95; borrow_pulse is high for exactly 1 cycle, coincident with the 99 that follows 0; zero_flag is high only while count_out = 0; BCD invariant checked every cycle.
- BCD borrow: load 40, then enable 2 cycles -> 39 (3/9), then 38 (3/8). Load 10, enable 1 cycle -> 09 (0/9).
- Load priority/saturation: load = 1 and enable = 1 with load_value = 57 -> 57 (5/7), not 56. load_value = 120 -> 99.
- Enable gating: count at 42, enable = 0 for 10 cycles -> 42 held, borrow_pulse = 0; re-enable -> 41 on the next edge.
- Parameter sweep: MAX_COUNT = 59 -> reset value 59, wrap 0 -> 59 with borrow_pulse, load 80 saturates to 59, BCD 5/9.

Source files
------------

// File: rtl/count_pkg.sv
// Constants and BCD helper shared by the mod-100 up and down counters.
package count_pkg;

    localparam int DEFAULT_WIDTH     = 7;
    localparam int DEFAULT_MAX_COUNT = 99;
    localparam int BCD_W             = 4;

    // Split a 0..99 binary value into {tens, units} BCD digits.
    function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [7:0] value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
        tens  = BCD_W'(value / 8'd10);
        units = BCD_W'(value % 8'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down 9..0 with borrow out; load overrides decrement.
// Latency: 1 clock; no backpressure, borrow_out is combinational from dec.
module bcd_digit_down
    import count_pkg::*;
(
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             dec,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic [BCD_W-1:0] reset_digit,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_d;
    logic [BCD_W-1:0] digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (dec) begin
            digit_d = (digit_q == '0) ? BCD_W'(9) : digit_q - BCD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            digit_q <= reset_digit;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec && (digit_q == '0);

endmodule

// File: rtl/count_descendente_100.sv
// Modulo-(MAX_COUNT+1) down counter with enable, saturating load, BCD view and wrap pulse.
// Latency: 1 clock from enable/load to count_out; no backpressure, enable simply gates counting.
module count_descendente_100
    import count_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_out,
    output logic [BCD_W-1:0] tens_bcd,
    output logic [BCD_W-1:0] units_bcd,
    output logic             zero_flag,
    output logic             borrow_pulse
);

    localparam logic [WIDTH-1:0]     MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [2*BCD_W-1:0]   MAX_BCD = to_bcd2(8'(MAX_COUNT));

    logic [WIDTH-1:0]   count_d, count_q;
    logic               borrow_d, borrow_q;
    logic [WIDTH-1:0]   load_sat;
    logic               do_dec, do_wrap, digit_load;
    logic [2*BCD_W-1:0] digit_load_val;
    logic               units_borrow;
    logic               tens_borrow_unused;

    always_comb begin
        load_sat       = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        do_dec         = !load && enable && (count_q != '0);
        do_wrap        = !load && enable && (count_q == '0);
        digit_load     = load || do_wrap;
        digit_load_val = load ? to_bcd2(8'(load_sat)) : MAX_BCD;

        count_d  = count_q;
        borrow_d = 1'b0;
        if (load) begin
            count_d = load_sat;
        end else if (do_dec) begin
            count_d = count_q - WIDTH'(1);
        end else if (do_wrap) begin
            count_d  = MAX_VAL;
            borrow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            count_q  <= MAX_VAL;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    // Units borrows into tens; the wrap and load cases override both digits.
    bcd_digit_down u_units (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .dec          (do_dec),
        .load         (digit_load),
        .load_digit   (digit_load_val[BCD_W-1:0]),
        .reset_digit  (MAX_BCD[BCD_W-1:0]),
        .digit        (units_bcd),
        .borrow_out   (units_borrow)
    );

    bcd_digit_down u_tens (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .dec          (units_borrow),
        .load         (digit_load),
        .load_digit   (digit_load_val[2*BCD_W-1:BCD_W]),
        .reset_digit  (MAX_BCD[2*BCD_W-1:BCD_W]),
        .digit        (tens_bcd),
        .borrow_out   (tens_borrow_unused)
    );

    assign count_out    = count_q;
    assign zero_flag    = (count_q == '0);
    assign borrow_pulse = borrow_q;

endmodule

// File: tb/tb_count_descendente_100.sv
// Bench for count_descendente_100 at MAX_COUNT 99 and 59, driven from shared inputs.
module tb_count_descendente_100;

    logic       clk = 1'b0;
    logic       async_reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_value = '0;

    logic [6:0] count_a, count_b;
    logic [3:0] tens_a, units_a, tens_b, units_b;
    logic       zero_a, zero_b, borrow_a, borrow_b;

    always #5 clk = ~clk;

    count_descendente_100 #(.WIDTH(7), .MAX_COUNT(99)) dut_a (
        .clk(clk), .async_reset_n(async_reset_n), .enable(enable), .load(load),
        .load_value(load_value), .count_out(count_a), .tens_bcd(tens_a),
        .units_bcd(units_a), .zero_flag(zero_a), .borrow_pulse(borrow_a)
    );

    count_descendente_100 #(.WIDTH(7), .MAX_COUNT(59)) dut_b (
        .clk(clk), .async_reset_n(async_reset_n), .enable(enable), .load(load),
        .load_value(load_value), .count_out(count_b), .tens_bcd(tens_b),
        .units_bcd(units_b), .zero_flag(zero_b), .borrow_pulse(borrow_b)
    );

    typedef struct {
        int ca;
        int ba;
        int cb;
        int bb;
    } exp_t;

    exp_t sb[$];
    int   model_a, model_b;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_count(int cur, int mx, bit en, bit ld, int lv);
        if (ld) return (lv > mx) ? mx : lv;
        if (en) return (cur == 0) ? mx : cur - 1;
        return cur;
    endfunction

    function automatic int next_borrow(int cur, bit en, bit ld);
        return (!ld && en && cur == 0) ? 1 : 0;
    endfunction

    task automatic compare_outputs(input exp_t e);
        check("a_count",  int'(count_a),  e.ca);
        check("a_tens",   int'(tens_a),   e.ca / 10);
        check("a_units",  int'(units_a),  e.ca % 10);
        check("a_zero",   int'(zero_a),   (e.ca == 0) ? 1 : 0);
        check("a_borrow", int'(borrow_a), e.ba);
        check("b_count",  int'(count_b),  e.cb);
        check("b_tens",   int'(tens_b),   e.cb / 10);
        check("b_units",  int'(units_b),  e.cb % 10);
        check("b_zero",   int'(zero_b),   (e.cb == 0) ? 1 : 0);
        check("b_borrow", int'(borrow_b), e.bb);
    endtask

    // Drive one cycle of stimulus, predict, then compare just after the edge.
    task automatic step(input bit en, input bit ld, input int lv);
        exp_t e;
        enable     = en;
        load       = ld;
        load_value = 7'(lv);
        e.ba    = next_borrow(model_a, en, ld);
        model_a = next_count(model_a, 99, en, ld, lv);
        e.ca    = model_a;
        e.bb    = next_borrow(model_b, en, ld);
        model_b = next_count(model_b, 59, en, ld, lv);
        e.cb    = model_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            compare_outputs(sb.pop_front());
        end
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e;
        model_a = 99;
        model_b = 59;
        e.ca = 99; e.ba = 0; e.cb = 59; e.bb = 0;
        sb.push_back(e);
        $display("reset check: %s", tag);
        compare_outputs(sb.pop_front());
    endtask

    initial begin
        model_a = 99;
        model_b = 59;
        #22;
        async_reset_n = 1'b1;
        #1;
        check_reset_state("after power-on reset");

        for (int i = 0; i < 105; i++) step(1'b1, 1'b0, 0);

        step(1'b0, 1'b1, 40);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 10);
        step(1'b1, 1'b0, 0);

        step(1'b1, 1'b1, 57);
        step(1'b0, 1'b1, 120);
        step(1'b0, 1'b1, 80);

        step(1'b0, 1'b1, 42);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0);
        enable = 1'b0;
        #2;
        async_reset_n = 1'b0;
        #1;
        check_reset_state("mid-cycle reset, no clock edge");
        #1;
        async_reset_n = 1'b1;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
